// File: rtl/tile_draw_scheduler.sv
// Two-requester tile painter for the 160x120 VGA plot port: grants one request,
// sweeps a TILE_SIZE^2 raster one pixel per clock. Define TILE_DRAW_RR_EN for round-robin.
module tile_draw_scheduler #(
    parameter int X0        = 40,
    parameter int Y0        = 20,
    parameter int SPACING   = 48,
    parameter int TILE_SIZE = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] tile0,
    input  logic [2:0] colour0,
    input  logic [1:0] tile1,
    input  logic [2:0] colour1,
    output logic [1:0] ack,
    output logic [1:0] done,
    output logic       busy,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot
);
    localparam int CW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(TILE_SIZE - 1);
    localparam logic [7:0] LX0 = 8'(X0);
    localparam logic [7:0] LY0 = 8'(Y0);
    localparam logic [7:0] LSP = 8'(SPACING);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t          r_state, w_next_state;
    logic            r_owner;
    logic [1:0]      r_tile;
    logic [2:0]      r_colour;
    logic [CW-1:0]   r_cx, r_cy;
    logic            w_win;
    logic            w_last_px;
    logic [7:0]      w_ox, w_oy;

`ifdef TILE_DRAW_RR_EN
    logic r_last;

    // Pointer names the requester granted most recently; contention goes to the other.
    always_ff @(posedge clock) begin
        if (reset)
            r_last <= 1'b1;
        else if (r_state == S_IDLE && req != 2'b00)
            r_last <= w_win;
    end

    always_comb begin
        w_win = req[1];
        if (req == 2'b11)
            w_win = ~r_last;
    end
`else
    always_comb begin
        w_win = ~req[0];
    end
`endif

    assign w_last_px = (r_cx == LAST) && (r_cy == LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (req != 2'b00) w_next_state = S_DRAW;
            S_DRAW:  if (w_last_px) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_tile   <= 2'b00;
            r_colour <= 3'b000;
            r_cx     <= '0;
            r_cy     <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && req != 2'b00) begin
                r_owner  <= w_win;
                r_tile   <= w_win ? tile1 : tile0;
                r_colour <= w_win ? colour1 : colour0;
                r_cx     <= '0;
                r_cy     <= '0;
            end else if (r_state == S_DRAW) begin
                // Power-of-two edge: both counters wrap to 0 on their own.
                r_cx <= r_cx + 1'b1;
                if (r_cx == LAST)
                    r_cy <= r_cy + 1'b1;
            end
        end
    end

    assign w_ox = LX0 + (r_tile[0] ? LSP : 8'd0);
    assign w_oy = LY0 + (r_tile[1] ? LSP : 8'd0);

    always_comb begin
        ack    = 2'b00;
        done   = 2'b00;
        busy   = 1'b0;
        x      = 8'd0;
        y      = 8'd0;
        colour = 3'b000;
        plot   = 1'b0;
        case (r_state)
            S_DRAW: begin
                plot   = 1'b1;
                busy   = 1'b1;
                x      = w_ox + 8'(r_cx);
                y      = w_oy + 8'(r_cy);
                colour = r_colour;
                // Counters are cleared at grant, so (0,0) marks the first DRAW cycle.
                if (r_cx == '0 && r_cy == '0)
                    ack = r_owner ? 2'b10 : 2'b01;
            end
            S_DONE: begin
                busy = 1'b1;
                done = r_owner ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_tile_draw_scheduler.sv
// Bench for tile_draw_scheduler: directed plan scenarios plus random traffic, all
// outputs checked every cycle against a queue-based model of expected plot cycles.
module tb_tile_draw_scheduler;
    localparam int N = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00, tile0 = 2'b00, tile1 = 2'b00;
    logic [2:0] colour0 = 3'b000, colour1 = 3'b000;
    logic [1:0] ack, done;
    logic       busy, plot;
    logic [7:0] x, y;
    logic [2:0] colour;

    tile_draw_scheduler dut (
        .clock(clock), .reset(reset), .req(req),
        .tile0(tile0), .colour0(colour0), .tile1(tile1), .colour1(colour1),
        .ack(ack), .done(done), .busy(busy),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x, y;
        logic [2:0] c;
        logic       p;
        logic [1:0] a, d;
        logic       b;
    } out_t;

    out_t q[$];
    out_t exp_o, m_rec;
    int   ptr = 1;
    int   m_w, m_ox, m_oy;
    logic [1:0] m_t;
    logic [2:0] m_c;
    int   total = 0, bad = 0;
    bit   chk_en = 0;

    function automatic out_t idle_o();
        out_t o;
        o.x = 0; o.y = 0; o.c = 0; o.p = 0; o.a = 0; o.d = 0; o.b = 0;
        return o;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", n, act, ex, $time);
        end
    endtask

    // Model: a grant expands into the full list of expected cycles (pixels then DONE);
    // each clock consumes one entry, and a new grant is possible only after an idle cycle.
    initial exp_o = idle_o();
    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            exp_o = idle_o();
            ptr = 1;
        end else if (q.size() != 0) begin
            exp_o = q.pop_front();
        end else if (exp_o.b == 1'b0 && req != 2'b00) begin
`ifdef TILE_DRAW_RR_EN
            if (req == 2'b11) m_w = 1 - ptr;
            else m_w = req[1] ? 1 : 0;
`else
            m_w = req[0] ? 0 : 1;
`endif
            ptr  = m_w;
            m_t  = m_w ? tile1 : tile0;
            m_c  = m_w ? colour1 : colour0;
            m_ox = 40 + (m_t[0] ? 48 : 0);
            m_oy = 20 + (m_t[1] ? 48 : 0);
            for (int r = 0; r < N; r++)
                for (int cc = 0; cc < N; cc++) begin
                    m_rec   = idle_o();
                    m_rec.x = 8'(m_ox + cc);
                    m_rec.y = 8'(m_oy + r);
                    m_rec.c = m_c;
                    m_rec.p = 1'b1;
                    m_rec.b = 1'b1;
                    if (r == 0 && cc == 0) m_rec.a = m_w ? 2'b10 : 2'b01;
                    q.push_back(m_rec);
                end
            m_rec   = idle_o();
            m_rec.b = 1'b1;
            m_rec.d = m_w ? 2'b10 : 2'b01;
            q.push_back(m_rec);
            exp_o = q.pop_front();
        end else begin
            exp_o = idle_o();
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_x", x, exp_o.x);
            chk("m_y", y, exp_o.y);
            chk("m_colour", colour, exp_o.c);
            chk("m_plot", plot, exp_o.p);
            chk("m_ack", ack, exp_o.a);
            chk("m_done", done, exp_o.d);
            chk("m_busy", busy, exp_o.b);
        end
    end

    // Waits for a grant, checks the first/last pixel, pixel count and done pulse.
    task automatic run_tile(input int own, input int fx, input int fy, input int lx,
                            input int ly, input bit disturb, output int wait_cyc);
        int  n, lastx, lasty;
        bit  got;
        got = 0; wait_cyc = 0; n = 0; lastx = 0; lasty = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            wait_cyc++;
            if (ack != 2'b00) begin got = 1; break; end
        end
        chk("ack_seen", got, 1);
        if (!got) return;
        chk("ack_owner", ack, 1 << own);
        chk("first_x", x, fx);
        chk("first_y", y, fy);
        req[own] = 1'b0;
        while (plot && n < 5000) begin
            n++;
            lastx = x; lasty = y;
            if (disturb && n == 100) begin
                tile0 = ~tile0; colour0 = ~colour0; req[1] = 1'b1;
            end
            @(negedge clock);
        end
        chk("plot_count", n, N * N);
        chk("last_x", lastx, lx);
        chk("last_y", lasty, ly);
        chk("done_pulse", done, 1 << own);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        int own;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_plot", plot, 0); chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);   chk("rst_done", done, 0);
        chk("rst_x", x, 0);       chk("rst_y", y, 0);
        chk_en = 1;
        reset = 1'b0;
        @(negedge clock);

        // single request, tile 0
        tile0 = 2'd0; colour0 = 3'b100; req = 2'b01;
        run_tile(0, 40, 20, 71, 51, 0, wc);
        chk("t1_latency", wc, 1);

        // origin map via requester 1
        tile1 = 2'd1; colour1 = 3'b010; req = 2'b10;
        run_tile(1, 88, 20, 119, 51, 0, wc);
        tile1 = 2'd2; req[1] = 1'b1;
        run_tile(1, 40, 68, 71, 99, 0, wc);
        chk("t2_back_to_back", wc, 2);
        tile1 = 2'd3; req[1] = 1'b1;
        run_tile(1, 88, 68, 119, 99, 0, wc);

        // contention held through two grants
        req = 2'b00;
        repeat (2) @(negedge clock);
        tile0 = 2'd0; colour0 = 3'b001; tile1 = 2'd3; colour1 = 3'b111;
        req = 2'b11;
        run_tile(0, 40, 20, 71, 51, 0, wc);
        run_tile(1, 88, 68, 119, 99, 0, wc);

        // contention repeated with simultaneous re-raise
        req = 2'b00;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            req = 2'b11;
`ifdef TILE_DRAW_RR_EN
            own = i % 2;
`else
            own = 0;
`endif
            if (own == 0) run_tile(0, 40, 20, 71, 51, 0, wc);
            else          run_tile(1, 88, 68, 119, 99, 0, wc);
        end

        // mid-draw disturbance
        req = 2'b00;
        repeat (2) @(negedge clock);
        tile0 = 2'd2; colour0 = 3'b101; tile1 = 2'd1; colour1 = 3'b110;
        req = 2'b01;
        run_tile(0, 40, 68, 71, 99, 1, wc);
        run_tile(1, 88, 20, 119, 51, 0, wc);
        chk("t5_ack_delay", wc, 2);

        // reset at pixel 500
        req = 2'b00;
        repeat (2) @(negedge clock);
        tile0 = 2'd1; colour0 = 3'b011; req = 2'b01;
        begin
            bit got = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clock);
                if (ack != 2'b00) begin got = 1; break; end
            end
            chk("t6_ack_seen", got, 1);
        end
        req = 2'b00;
        for (int k = 1; k < 500; k++) @(negedge clock);
        chk("t6_pixel500_x", x, 88 + (499 % 32));
        reset = 1'b1;
        @(negedge clock);
        chk("t6_plot", plot, 0); chk("t6_busy", busy, 0);
        chk("t6_ack", ack, 0);   chk("t6_done", done, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("t6_no_done", done, 0);
        req = 2'b01;
        run_tile(0, 88, 20, 119, 51, 0, wc);
        req = 2'b00;

        // random traffic, including occasional resets
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(posedge clock);
            #1;
            req     = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
            tile0   = 2'($urandom);
            tile1   = 2'($urandom);
            colour0 = 3'($urandom);
            colour1 = 3'($urandom);
            reset   = ($urandom_range(0, 2999) == 0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        req = 2'b00;
        repeat (3) @(negedge clock);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
